// File: rtl/wb_stage_pipe.sv
// Purpose : M/W pipeline register merged with the write-back selector. It also extracts
//           sub-word loads, suppresses writes to $0, and counts retired instructions.
// Latency : M inputs captured at edge n drive waddr/wback/regwrite combinationally in cycle n+1.
// Backpr. : en=0 stalls and holds W. flush loads a bubble and overrides a stall.
//           An instruction retires on any edge where valid_W=1 and en=1.
// Ports   : clk/reset (async, active-high); en, flush; valid_M/instr_M/alu_M/dr_M/pc8_M from MEM;
//           waddr/wback/regwrite to the GRF; valid_W/instr_W as a hazard tap; retire_cnt.
// DATA_W must be 32 or 64. Loads always extract from the low 32 bits of the memory word.
module wb_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               flush,
  input  logic               valid_M,
  input  logic [31:0]        instr_M,
  input  logic [DATA_W-1:0]  alu_M,
  input  logic [31:0]        dr_M,
  input  logic [DATA_W-1:0]  pc8_M,
  output logic [RADDR_W-1:0] waddr,
  output logic [DATA_W-1:0]  wback,
  output logic               regwrite,
  output logic               valid_W,
  output logic [31:0]        instr_W,
  output logic [CNT_W-1:0]   retire_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  // W register
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] alu_q,   alu_d;
  logic [31:0]       dr_q,    dr_d;
  logic [DATA_W-1:0] pc8_q,   pc8_d;
  logic [1:0]        off_q,   off_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    alu_d   = alu_q;
    dr_d    = dr_q;
    pc8_d   = pc8_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    // The W instruction leaves on any advancing edge, including one that also flushes.
    if (valid_q && en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (flush) begin
      valid_d = 1'b0;
      instr_d = '0;
      alu_d   = '0;
      dr_d    = '0;
      pc8_d   = '0;
      off_d   = '0;
    end else if (en) begin
      valid_d = valid_M;
      instr_d = instr_M;
      alu_d   = alu_M;
      dr_d    = dr_M;
      pc8_d   = pc8_M;
      off_d   = alu_M[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      alu_q   <= '0;
      dr_q    <= '0;
      pc8_q   <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      alu_q   <= alu_d;
      dr_q    <= dr_d;
      pc8_q   <= pc8_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end

  // Instruction class decode from the registered word
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt_f;
  logic       is_cal_r, is_r_h_l, is_jalr, is_cal_i, is_load, is_jal, is_bgezal, is_bltzal;
  logic       writes;

  assign opcode    = instr_q[31:26];
  assign funct     = instr_q[5:0];
  assign rt_f      = instr_q[20:16];

  assign is_cal_r  = (opcode == OP_SPECIAL) &&
                     (funct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                    6'h26, 6'h27, 6'h2a, 6'h2b});
  assign is_r_h_l  = (opcode == OP_SPECIAL) && ((funct == FN_MFHI) || (funct == FN_MFLO));
  assign is_jalr   = (opcode == OP_SPECIAL) && (funct == FN_JALR);
  assign is_cal_i  = (opcode inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f});
  assign is_load   = (opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU});
  assign is_jal    = (opcode == OP_JAL);
  assign is_bgezal = (opcode == OP_REGIMM) && (rt_f == RT_BGEZAL);
  assign is_bltzal = (opcode == OP_REGIMM) && (rt_f == RT_BLTZAL);

  assign writes    = is_cal_r | is_r_h_l | is_jalr | is_cal_i | is_load |
                     is_jal | is_bgezal | is_bltzal;

  // Sub-word load extraction. Offset bits below the access size are ignored.
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_val;

  always_comb begin
    case (off_q)
      2'd0:    byte_sel = dr_q[7:0];
      2'd1:    byte_sel = dr_q[15:8];
      2'd2:    byte_sel = dr_q[23:16];
      default: byte_sel = dr_q[31:24];
    endcase
    half_sel = off_q[1] ? dr_q[31:16] : dr_q[15:0];
    case (opcode)
      OP_LW:   load_val = DATA_W'($signed(dr_q));
      OP_LH:   load_val = DATA_W'($signed(half_sel));
      OP_LHU:  load_val = DATA_W'(half_sel);
      OP_LB:   load_val = DATA_W'($signed(byte_sel));
      OP_LBU:  load_val = DATA_W'(byte_sel);
      default: load_val = '0;
    endcase
  end

  // Write-back address and data. These are shown even when regwrite is suppressed.
  always_comb begin
    waddr = '0;
    wback = '0;
    if (is_cal_r || is_r_h_l || is_jalr) begin
      waddr = RADDR_W'(instr_q[15:11]);
    end else if (is_cal_i || is_load) begin
      waddr = RADDR_W'(instr_q[20:16]);
    end else if (is_jal || is_bgezal || is_bltzal) begin
      waddr = RADDR_W'(LINK_REG);
    end
    if (is_cal_r || is_cal_i || is_r_h_l) begin
      wback = alu_q;
    end else if (is_jal || is_jalr || is_bgezal || is_bltzal) begin
      wback = pc8_q;
    end else if (is_load) begin
      wback = load_val;
    end
  end

  assign regwrite   = valid_q && writes && (waddr != '0);
  assign valid_W    = valid_q;
  assign instr_W    = instr_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        reset, en, flush, valid_M;
  logic [31:0] instr_M, alu_M, dr_M, pc8_M;
  logic [4:0]  waddr;
  logic [31:0] wback;
  logic        regwrite, valid_W;
  logic [31:0] instr_W, retire_cnt;

  wb_stage_pipe dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_M(valid_M),
    .instr_M(instr_M), .alu_M(alu_M), .dr_M(dr_M), .pc8_M(pc8_M),
    .waddr(waddr), .wback(wback), .regwrite(regwrite), .valid_W(valid_W),
    .instr_W(instr_W), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: W contents plus retired count
  typedef struct {
    logic        valid;
    logic [31:0] instr, alu, dr, pc8, cnt;
  } mstate_t;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [4:0]  waddr;
    logic [31:0] wback;
    logic        regwrite;
    logic [31:0] cnt;
  } exp_t;

  typedef enum int {K_NONE, K_RD_ALU, K_RT_ALU, K_RT_LOAD, K_LINK, K_RD_PC8} kind_t;

  localparam logic [5:0] RTAB [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                       6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                                       6'h10, 6'h12, 6'h09, 6'h18};
  localparam logic [5:0] LTAB [5] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  localparam logic [5:0] OTAB [5] = '{6'h04, 6'h05, 6'h2b, 6'h28, 6'h02};

  mstate_t m;
  exp_t    q[$];
  int      checks = 0;
  int      errors = 0;
  bit      mon_en = 1'b0;
  logic [31:0] saved_cnt;

  function automatic kind_t classify(input logic [31:0] i);
    logic [5:0] op, fn;
    logic [4:0] rt;
    op = i[31:26];
    fn = i[5:0];
    rt = i[20:16];
    if (op == 6'h00) begin
      if (fn == 6'h09) return K_RD_PC8;                      // jalr
      if (fn inside {6'h10, 6'h12}) return K_RD_ALU;         // mfhi/mflo
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) return K_RD_ALU; // shifts
      if (fn inside {[6'h20:6'h27], 6'h2a, 6'h2b}) return K_RD_ALU;             // arith/logic/slt
      return K_NONE;
    end
    if (op inside {[6'h08:6'h0f]}) return K_RT_ALU;
    if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return K_RT_LOAD;
    if (op == 6'h03) return K_LINK;
    if (op == 6'h01 && rt inside {5'h10, 5'h11}) return K_LINK;
    return K_NONE;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] i, input logic [31:0] dr,
                                             input logic [1:0] off);
    logic [31:0] b, h;
    b = (dr >> (8 * off)) & 32'hff;
    h = (dr >> (16 * (off / 2))) & 32'hffff;
    case (i[31:26])
      6'h23:   return dr;
      6'h21:   return h[15] ? (h | 32'hffff0000) : h;
      6'h25:   return h;
      6'h20:   return b[7] ? (b | 32'hffffff00) : b;
      6'h24:   return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic exp_t expect_of(input mstate_t s);
    exp_t  e;
    kind_t k;
    k = classify(s.instr);
    e.valid = s.valid;
    e.instr = s.instr;
    e.cnt   = s.cnt;
    e.waddr = 5'd0;
    e.wback = 32'd0;
    case (k)
      K_RD_ALU:  begin e.waddr = s.instr[15:11]; e.wback = s.alu; end
      K_RT_ALU:  begin e.waddr = s.instr[20:16]; e.wback = s.alu; end
      K_RT_LOAD: begin e.waddr = s.instr[20:16]; e.wback = load_value(s.instr, s.dr, s.alu[1:0]); end
      K_LINK:    begin e.waddr = 5'd31;          e.wback = s.pc8; end
      K_RD_PC8:  begin e.waddr = s.instr[15:11]; e.wback = s.pc8; end
      default:   ;
    endcase
    e.regwrite = s.valid && (k != K_NONE) && (e.waddr != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 8))
      0, 1: begin r[31:26] = 6'h00; r[5:0] = RTAB[$urandom_range(0, 19)]; end
      2:    r[31:26] = 6'($urandom_range(8, 15));
      3, 4: r[31:26] = LTAB[$urandom_range(0, 4)];
      5:    r[31:26] = 6'h03;
      6:    begin r[31:26] = 6'h01; r[20:16] = 5'($urandom_range(15, 17)); end
      7:    r[31:26] = OTAB[$urandom_range(0, 4)];
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) r[20:11] = '0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m.valid = 1'b0; m.instr = '0; m.alu = '0; m.dr = '0; m.pc8 = '0; m.cnt = '0;
  endtask

  // Drive one M-stage cycle and push the W outputs expected after the coming edge
  task automatic step(input logic v, input logic [31:0] i, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] p, input logic e_, input logic f_);
    @(negedge clk);
    valid_M = v; instr_M = i; alu_M = a; dr_M = d; pc8_M = p; en = e_; flush = f_;
    if (e_ && m.valid) m.cnt = m.cnt + 1;
    if (f_) begin
      m.valid = 1'b0; m.instr = '0; m.alu = '0; m.dr = '0; m.pc8 = '0;
    end else if (e_) begin
      m.valid = v; m.instr = i; m.alu = a; m.dr = d; m.pc8 = p;
    end
    q.push_back(expect_of(m));
  endtask

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  // Monitor: compares every cycle the DUT has produced a W state for
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en && q.size() > 0) begin
        e = q.pop_front();
        chk("sb_valid_W",  32'(valid_W),  32'(e.valid));
        chk("sb_instr_W",  instr_W,       e.instr);
        chk("sb_waddr",    32'(waddr),    32'(e.waddr));
        chk("sb_wback",    wback,         e.wback);
        chk("sb_regwrite", 32'(regwrite), 32'(e.regwrite));
        chk("sb_retire",   retire_cnt,    e.cnt);
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0; valid_M = 1'b0;
    instr_M = '0; alu_M = '0; dr_M = '0; pc8_M = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid_W",  32'(valid_W),  0);
    chk("rst_instr_W",  instr_W,       0);
    chk("rst_waddr",    32'(waddr),    0);
    chk("rst_wback",    wback,         0);
    chk("rst_regwrite", 32'(regwrite), 0);
    chk("rst_retire",   retire_cnt,    0);
    reset = 1'b0;
    mon_en = 1'b1;

    // addu $3,$1,$2
    step(1, 32'h00221821, 32'h7, 32'h0, 32'h0, 1, 0);
    after_edge();
    chk("addu_waddr", 32'(waddr), 3);
    chk("addu_wback", wback, 32'h7);
    chk("addu_rw", 32'(regwrite), 1);
    step(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
    after_edge();
    chk("addu_retire", retire_cnt, 1);

    // sub-word loads
    step(1, 32'h80050001, 32'h1, 32'h12348034, 32'h0, 1, 0);
    after_edge();
    chk("lb_wback", wback, 32'hFFFFFF80);
    chk("lb_waddr", 32'(waddr), 5);
    step(1, 32'h90050001, 32'h1, 32'h12348034, 32'h0, 1, 0);
    after_edge();
    chk("lbu_wback", wback, 32'h00000080);
    step(1, 32'h94050002, 32'h2, 32'h12348034, 32'h0, 1, 0);
    after_edge();
    chk("lhu_wback", wback, 32'h00001234);
    step(1, 32'h84050003, 32'h1, 32'h12348034, 32'h0, 1, 0);
    after_edge();
    chk("lh_misalign_wback", wback, 32'hFFFF8034);
    step(1, 32'h8C050003, 32'h3, 32'h12348034, 32'h0, 1, 0);
    after_edge();
    chk("lw_misalign_wback", wback, 32'h12348034);

    // jal, write to $0, bubble carrying a non-zero word
    step(1, 32'h0C000010, 32'h0, 32'h0, 32'h00003008, 1, 0);
    after_edge();
    chk("jal_waddr", 32'(waddr), 31);
    chk("jal_wback", wback, 32'h3008);
    chk("jal_rw", 32'(regwrite), 1);
    step(1, 32'h34000005, 32'h5, 32'h0, 32'h0, 1, 0);
    after_edge();
    chk("ori0_waddr", 32'(waddr), 0);
    chk("ori0_rw", 32'(regwrite), 0);
    step(0, 32'h00221821, 32'h9, 32'h0, 32'h0, 1, 0);
    after_edge();
    chk("bubble_rw", 32'(regwrite), 0);

    // stall holds W and the counter
    step(1, 32'h00221821, 32'h11, 32'h0, 32'h0, 1, 0);
    saved_cnt = m.cnt;
    for (int s = 0; s < 3; s++) begin
      step(1, 32'h34070000 + s, 32'h40 + s, 32'h55 + s, 32'h66, 0, 0);
      after_edge();
      chk("stall_instr", instr_W, 32'h00221821);
      chk("stall_wback", wback, 32'h11);
      chk("stall_retire", retire_cnt, saved_cnt);
    end
    step(1, 32'h34070009, 32'h9, 32'h0, 32'h0, 1, 0);
    after_edge();
    chk("unstall_retire", retire_cnt, saved_cnt + 1);
    chk("unstall_waddr", 32'(waddr), 7);

    // flush wins over a stall
    step(1, 32'h00221821, 32'h3, 32'h0, 32'h0, 0, 1);
    after_edge();
    chk("flush_valid", 32'(valid_W), 0);
    chk("flush_rw", 32'(regwrite), 0);
    chk("flush_instr", instr_W, 0);

    // asynchronous reset during a stall with a valid write in W
    step(1, 32'h00221821, 32'h7, 32'h0, 32'h0, 1, 0);
    step(1, 32'h34070001, 32'h1, 32'h0, 32'h0, 0, 0);
    after_edge();
    chk("pre_areset_rw", 32'(regwrite), 1);
    reset = 1'b1;
    #1;
    chk("areset_rw", 32'(regwrite), 0);
    chk("areset_waddr", 32'(waddr), 0);
    chk("areset_wback", wback, 0);
    chk("areset_retire", retire_cnt, 0);
    reset = 1'b0;
    model_reset();
    q.delete();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      step(1'($urandom_range(0, 9) < 8), rand_instr(), $urandom(), $urandom(), $urandom(),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
    end
    after_edge();
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
